mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Two-port arbiter that shares one single-port byte memory between two requesters, e.g. CPU on port 0 and a DMA/video fetcher on port 1.
- Fair round-robin selection, one memory access per transaction.
- Drives registered read/write/address/data strobes into the memory. Samples the memory's combinational read data.
- Returns a one-cycle ack plus read data to the winning requester. Sits between the requesters and the memory instance.

Parameters:
- ADDR_W, 16, address width of requester and memory ports.
- DATA_W, 8, data width.
- MEM_SIZE, 'h1000, number of valid memory locations. Addresses >= MEM_SIZE are rejected.

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset_n  input  1  synchronous active-low reset.
- req0  input  1  port 0 request; held with we0/addr0/wdata0 stable until ack0.
- we0  input  1  port 0 write (1) / read (0).
- addr0  input  ADDR_W  port 0 address.
- wdata0  input  DATA_W  port 0 write data.
- ack0  output  1  one-cycle completion pulse for port 0.
- req1, we1, addr1, wdata1, ack1: same as port 0, for port 1.
- rdata  output  DATA_W  read data; valid in the ack cycle of a read.
- err  output  1  out-of-range flag; valid in the ack cycle.
- busy  output  1  high while state != IDLE.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data; combinational from mem_addr while mem_read=1.

Behaviour:
- Reset (reset_n=0 at posedge):
  - State -> IDLE.
  - ack0, ack1, err, mem_read, mem_write = 0.
  - rdata, mem_addr, mem_wdata = 0.
  - last_grant = 1, so port 0 wins the first contention.
- Reset mid-transaction: the transaction is dropped, no ack is issued, and a memory write not yet clocked does not occur. The requester must re-request.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If no req, stay in IDLE.
  - Otherwise pick a winner: if only one port requests, that port wins. If both request, the winner is port (~last_grant).
  - Latch winner, we, addr, wdata. Update last_grant = winner.
  - Go to ACCESS.
  - In-range address (addr < MEM_SIZE): on the same edge, mem_addr <= addr, mem_wdata <= wdata, mem_write <= we, mem_read <= ~we.
  - Out-of-range address: mem_read and mem_write stay 0, and an error flag is latched internally.
- ACCESS (exactly one cycle):
  - The memory commits a write on the edge leaving ACCESS.
  - On that edge:
    - rdata <= (read && in range) ? mem_rdata : 0.
    - err <= out-of-range flag.
    - ack(winner) <= 1.
    - mem_read, mem_write, mem_addr, mem_wdata <= 0.
  - Go to DONE.
- DONE (one cycle):
  - ack(winner)=1, rdata/err valid.
  - Next edge: ack, err <= 0. rdata holds its value until the next ACCESS exit.
  - Go to IDLE.
- Latency: req seen at edge N -> strobes high in cycle N+1 -> ack high in cycle N+2. Three cycles per transaction; the next arbitration is at edge N+3.
- Back-to-back: a requester keeping req high after ack is treated as a new request in IDLE. With both ports continuously requesting, grants alternate 0,1,0,1.
- Requests arriving while busy are not sampled until IDLE. Inputs changing before ack have no effect after latching.
- mem_read and mem_write are never both 1, and are never 1 outside ACCESS.
- ack0 and ack1 are never both 1.

Test Plan:
- Single write then read on port 0: write addr 0x0010 data 0xA5 -> mem_write=1 with addr 0x0010/wdata 0xA5 for exactly one cycle, ack0 two cycles after req. Then read 0x0010 -> ack0 with rdata=0xA5, err=0.
- Contention from reset: req0 and req1 both high with reads of 0x0001 and 0x0002 -> port 0 acked first, port 1 acked 3 cycles later. Continued requests alternate grants, and no ack0/ack1 overlap.
- Out of range: port 1 reads 0x1000 (MEM_SIZE 'h1000) -> mem_read stays 0, ack1 with err=1 and rdata=0. A following in-range read has err=0.
- Reset in ACCESS: port 0 write 0x0020=0x5A with reset_n=0 during ACCESS -> no ack0 and all outputs 0 next cycle. A later read of 0x0020 returns the prior contents, not 0x5A.
- Stability: change addr0 while busy after latching -> the memory sees the originally latched address. busy is high for exactly 2 cycles per transaction.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port byte memory.
// Each transaction takes three cycles: arbitrate (IDLE), strobe memory (ACCESS),
// and ack to the requester (DONE).
`timescale 1ns/1ps

module mem_arbiter #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MEM_SIZE = 'h1000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              busy,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // One extra bit so a MEM_SIZE equal to 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] MemLimit = (ADDR_W + 1)'(MEM_SIZE);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e              state_q;
  logic                last_grant_q;
  logic                win_q;
  logic                oor_q;
  logic                ack0_q, ack1_q, err_q;
  logic                mem_read_q, mem_write_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [DATA_W-1:0]   rdata_q;

  logic                grant;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_in_range;

  // Pick the winning port and mux its request fields.
  always_comb begin
    grant        = req1 & (~req0 | ~last_grant_q);
    sel_we       = grant ? we1    : we0;
    sel_addr     = grant ? addr1  : addr0;
    sel_wdata    = grant ? wdata1 : wdata0;
    sel_in_range = ({1'b0, sel_addr} < MemLimit);
  end

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      win_q        <= 1'b0;
      oor_q        <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      err_q        <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rdata_q      <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req0 || req1) begin
            win_q        <= grant;
            last_grant_q <= grant;
            oor_q        <= ~sel_in_range;
            if (sel_in_range) begin
              mem_addr_q  <= sel_addr;
              mem_wdata_q <= sel_wdata;
              mem_write_q <= sel_we;
              mem_read_q  <= ~sel_we;
            end
            state_q <= StAccess;
          end
        end
        StAccess: begin
          // mem_read_q is only ever set for an in-range read.
          rdata_q     <= mem_read_q ? mem_rdata : '0;
          err_q       <= oor_q;
          ack0_q      <= ~win_q;
          ack1_q      <= win_q;
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
          state_q     <= StDone;
        end
        StDone: begin
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          err_q   <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign busy      = (state_q != StIdle);
  assign mem_read  = mem_read_q;
  // The memory commits on the edge leaving ACCESS; masking with reset_n keeps a
  // write from landing when reset arrives during that cycle.
  assign mem_write = mem_write_q & reset_n;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
